ovi_issue_queue: RTL and testbench

OVI_ISSUE_QUEUE -- requirements
Module: ovi_issue_queue

---
 rtl/ovi_issue_queue.sv | 212 +++++++++++++++++++++
 tb/tb_ovi_issue_queue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovi_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : ovi_issue_queue
// Purpose  : Core-to-vector-unit issue FIFO with credit-based dispatch,
//            outstanding-instruction tracking and completion forwarding.
//            Instructions are queued from the core and dispatched to the
//            vector unit one per cycle while issue credits remain. Each
//            dispatch consumes one credit and adds one outstanding
//            instruction. The vector unit hands credits back on issue_credit
//            and retires instructions on vu_completed_valid. Each retirement
//            is forwarded to the core one cycle later.
// Ports    :
//   CLK, RST                 clock, asynchronous active-high reset
//   in_valid/in_ready        core-side issue handshake
//   in_instr/opnd/vl/sew/wb  instruction fields written at the FIFO tail
//   issue_valid + issue_*    dispatch of the FIFO head (no downstream ready)
//   issue_credit             one credit returned per high cycle
//   vu_completed_valid/data  completion from the vector unit
//   core_completed_valid/data registered completion towards the core
//   flush                    drop every undispatched entry
//   idle                     FIFO empty and nothing outstanding
//   credit_err, cmpl_err     sticky protocol-error flags (cleared by RST)
// Params   : DEPTH (power of two, >= 2), CREDITS (1..15), INSTR_W, OPND_W,
//            VL_W, SEW_W
// Revision : 1.0 - initial release
// ============================================================================
module ovi_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int INSTR_W = 32,
  parameter int OPND_W  = 64,
  parameter int VL_W    = 14,
  parameter int SEW_W   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  // core-side issue request
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [OPND_W-1:0]  in_opnd,
  input  logic [VL_W-1:0]    in_vl,
  input  logic [SEW_W-1:0]   in_sew,
  input  logic               in_wb,
  output logic               in_ready,
  // dispatch to vector unit
  output logic               issue_valid,
  output logic [INSTR_W-1:0] issue_instr,
  output logic [OPND_W-1:0]  issue_opnd,
  output logic [VL_W-1:0]    issue_vl,
  output logic [SEW_W-1:0]   issue_sew,
  output logic               issue_wb,
  input  logic               issue_credit,
  // completions
  input  logic               vu_completed_valid,
  input  logic [OPND_W-1:0]  vu_completed_data,
  output logic               core_completed_valid,
  output logic [OPND_W-1:0]  core_completed_data,
  // control / status
  input  logic               flush,
  output logic               idle,
  output logic               credit_err,
  output logic               cmpl_err
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam int c_OW = $clog2(CREDITS + 1);
  localparam int c_EW = INSTR_W + OPND_W + VL_W + SEW_W + 1;

  localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
  localparam logic [3:0]      c_CREDITS = 4'(CREDITS);
  localparam logic [3:0]      c_CRD_ONE = 4'd1;
  localparam logic [c_OW-1:0] c_OUT_ONE = c_OW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_EW-1:0]   r_mem [DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [3:0]        r_credits;
  logic [c_OW-1:0]   r_outstanding;
  logic              r_credit_err;
  logic              r_cmpl_err;
  logic              r_cc_valid;
  logic [OPND_W-1:0] r_cc_data;

  // --------------------------------------------------------------------------
  // Handshake decode (all from registered state plus current inputs)
  // --------------------------------------------------------------------------
  logic w_push;
  logic w_pop;
  logic w_credit_over;
  logic w_cmpl_ok;
  logic w_cmpl_bad;

  // in_ready looks only at the registered count: a pop in the same cycle
  // does not open a slot until the next edge.
  assign in_ready    = (r_count < c_DEPTH);
  assign w_push      = in_valid && in_ready && !flush;
  assign issue_valid = (r_count != '0) && (r_credits != '0) && !flush;
  // No downstream ready: every issue_valid cycle is a transfer.
  assign w_pop       = issue_valid;

  // A return with a simultaneous dispatch is a net no-op, so only a lone
  // return at the full credit level is an overflow.
  assign w_credit_over = issue_credit && !w_pop && (r_credits == c_CREDITS);

  // A completion is legitimate if something is in flight, including the
  // instruction being dispatched this very cycle.
  assign w_cmpl_ok  = vu_completed_valid && ((r_outstanding != '0) || w_pop);
  assign w_cmpl_bad = vu_completed_valid && !w_cmpl_ok;

  // --------------------------------------------------------------------------
  // FIFO storage (no reset; the head is only meaningful under issue_valid)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_instr, in_opnd, in_vl, in_sew, in_wb};
    end
  end

  assign {issue_instr, issue_opnd, issue_vl, issue_sew, issue_wb} = r_mem[r_rd_ptr];

  // --------------------------------------------------------------------------
  // Pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Push and pop are both blocked during flush, so the queue simply
      // restarts from slot 0.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Issue credits
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_credits    <= c_CREDITS;
      r_credit_err <= 1'b0;
    end else begin
      if (issue_credit && !w_pop && !w_credit_over) begin
        r_credits <= r_credits + c_CRD_ONE;
      end else if (w_pop && !issue_credit) begin
        r_credits <= r_credits - c_CRD_ONE;
      end
      if (w_credit_over) begin
        r_credit_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding instructions and completion forwarding
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_outstanding <= '0;
      r_cmpl_err    <= 1'b0;
      r_cc_valid    <= 1'b0;
      r_cc_data     <= '0;
    end else begin
      if (w_pop && !w_cmpl_ok) begin
        r_outstanding <= r_outstanding + c_OUT_ONE;
      end else if (w_cmpl_ok && !w_pop) begin
        r_outstanding <= r_outstanding - c_OUT_ONE;
      end
      if (w_cmpl_bad) begin
        r_cmpl_err <= 1'b1;
      end
      r_cc_valid <= w_cmpl_ok;
      if (w_cmpl_ok) begin
        r_cc_data <= vu_completed_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign core_completed_valid = r_cc_valid;
  assign core_completed_data  = r_cc_data;
  assign idle                 = (r_count == '0) && (r_outstanding == '0);
  assign credit_err           = r_credit_err;
  assign cmpl_err             = r_cmpl_err;

endmodule
`default_nettype wire

// File: tb/tb_ovi_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ovi_issue_queue
// Purpose  : Self-checking bench for ovi_issue_queue. Accepted pushes and
//            expected completions are queued by the stimulus tasks and
//            retired by a monitor that compares every dispatch/completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ovi_issue_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] opnd;
    logic [13:0] vl;
    logic [1:0]  sew;
    logic        wb;
  } entry_t;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_opnd;
  logic [13:0] in_vl;
  logic [1:0]  in_sew;
  logic        in_wb;
  logic        in_ready;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [63:0] issue_opnd;
  logic [13:0] issue_vl;
  logic [1:0]  issue_sew;
  logic        issue_wb;
  logic        issue_credit;
  logic        vu_completed_valid;
  logic [63:0] vu_completed_data;
  logic        core_completed_valid;
  logic [63:0] core_completed_data;
  logic        flush;
  logic        idle;
  logic        credit_err;
  logic        cmpl_err;

  int n_cmp;
  int n_fail;
  int n_issued;

  entry_t      q_issue[$];
  logic [63:0] q_cmpl[$];

  ovi_issue_queue #(
    .DEPTH(4), .CREDITS(4), .INSTR_W(32), .OPND_W(64), .VL_W(14), .SEW_W(2)
  ) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_instr(in_instr), .in_opnd(in_opnd),
    .in_vl(in_vl), .in_sew(in_sew), .in_wb(in_wb), .in_ready(in_ready),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_opnd(issue_opnd),
    .issue_vl(issue_vl), .issue_sew(issue_sew), .issue_wb(issue_wb),
    .issue_credit(issue_credit),
    .vu_completed_valid(vu_completed_valid), .vu_completed_data(vu_completed_data),
    .core_completed_valid(core_completed_valid), .core_completed_data(core_completed_data),
    .flush(flush), .idle(idle), .credit_err(credit_err), .cmpl_err(cmpl_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog: every scenario is a fixed number of cycles, this only guards
  // against a broken simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Scoreboard monitor: sampled 2 time units after the falling edge, after
  // the stimulus of that cycle has settled.
  // --------------------------------------------------------------------------
  entry_t m_exp;
  logic [63:0] m_cexp;

  always @(negedge CLK) begin
    #2;
    if (!RST) begin
      if (issue_valid) begin
        n_issued++;
        n_cmp++;
        if (q_issue.size() == 0) begin
          n_fail++;
          $display("FAIL sb_issue_unexpected: got instr %h, nothing expected", issue_instr);
        end else begin
          m_exp = q_issue.pop_front();
          if ({issue_instr, issue_opnd, issue_vl, issue_sew, issue_wb} !== m_exp) begin
            n_fail++;
            $display("FAIL sb_issue_data: got %h want %h",
                     {issue_instr, issue_opnd, issue_vl, issue_sew, issue_wb}, m_exp);
          end
        end
      end
      if (core_completed_valid) begin
        n_cmp++;
        if (q_cmpl.size() == 0) begin
          n_fail++;
          $display("FAIL sb_cmpl_unexpected: got data %h, nothing expected", core_completed_data);
        end else begin
          m_cexp = q_cmpl.pop_front();
          if (core_completed_data !== m_cexp) begin
            n_fail++;
            $display("FAIL sb_cmpl_data: got %h want %h", core_completed_data, m_cexp);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  function automatic entry_t mk(input logic [31:0] instr);
    entry_t e;
    e.instr = instr;
    e.opnd  = {~instr, instr};
    e.vl    = instr[13:0];
    e.sew   = instr[1:0];
    e.wb    = instr[0];
    return e;
  endfunction

  task automatic idle_inputs();
    in_valid           = 1'b0;
    in_instr           = '0;
    in_opnd            = '0;
    in_vl              = '0;
    in_sew             = '0;
    in_wb              = 1'b0;
    issue_credit       = 1'b0;
    vu_completed_valid = 1'b0;
    vu_completed_data  = '0;
    flush              = 1'b0;
  endtask

  task automatic drive_push(input entry_t e);
    in_valid = 1'b1;
    in_instr = e.instr;
    in_opnd  = e.opnd;
    in_vl    = e.vl;
    in_sew   = e.sew;
    in_wb    = e.wb;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    q_issue.delete();
    q_cmpl.delete();
    RST = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_issue_valid: got %b want 0", issue_valid); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", idle); end
    n_cmp++; if ({credit_err, cmpl_err} !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b want 00", {credit_err, cmpl_err}); end
    n_cmp++; if (core_completed_valid !== 1'b0 || core_completed_data !== 64'd0) begin n_fail++; $display("FAIL rst_cc: got %b/%h want 0/0", core_completed_valid, core_completed_data); end
    n_cmp++; if (dut.r_credits !== 4'd4) begin n_fail++; $display("FAIL rst_credits: got %0d want 4", dut.r_credits); end
    n_cmp++; if (dut.r_count !== 3'd0 || dut.r_outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_counts: got count %0d outst %0d want 0 0", dut.r_count, dut.r_outstanding); end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK); #1;
    n_cmp++; if ({in_ready, issue_valid, idle} !== 3'b101) begin n_fail++; $display("FAIL post_rst_outputs: got %b want 101", {in_ready, issue_valid, idle}); end
  endtask

  task automatic test_single();
    entry_t e;
    do_reset();
    e = mk(32'h0200A057);
    @(negedge CLK); drive_push(e); #1;  // cycle 0
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    if (in_ready) q_issue.push_back(e);
    @(negedge CLK); idle_inputs(); #1;  // cycle 1
    n_cmp++; if (issue_valid !== 1'b1 || issue_instr !== 32'h0200A057) begin n_fail++; $display("FAIL single_issue: got %b/%h want 1/0200a057", issue_valid, issue_instr); end
    @(negedge CLK); #1;                 // cycle 2
    n_cmp++; if (dut.r_credits !== 4'd3) begin n_fail++; $display("FAIL single_credits: got %0d want 3", dut.r_credits); end
    n_cmp++; if (issue_valid !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL single_after: got valid %b idle %b want 0 0", issue_valid, idle); end
    repeat (2) @(negedge CLK);          // cycles 3, 4
    @(negedge CLK);                     // cycle 5
    vu_completed_valid = 1'b1;
    vu_completed_data  = 64'hC0FF_EE00_1234_5678;
    q_cmpl.push_back(64'hC0FF_EE00_1234_5678);
    @(negedge CLK); idle_inputs(); #1;  // cycle 6
    n_cmp++; if (core_completed_valid !== 1'b1 || core_completed_data !== 64'hC0FF_EE00_1234_5678) begin n_fail++; $display("FAIL single_cmpl: got %b/%h want 1/c0ffee0012345678", core_completed_valid, core_completed_data); end
    @(negedge CLK); #1;                 // cycle 7
    n_cmp++; if (idle !== 1'b1 || core_completed_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got idle %b ccv %b want 1 0", idle, core_completed_valid); end
  endtask

  task automatic test_starvation();
    entry_t e;
    int base;
    do_reset();
    base = n_issued;
    for (int i = 0; i < 6; i++) begin
      e = mk(32'h1000_0000 + 32'(i));
      @(negedge CLK); drive_push(e); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL starve_in_ready_%0d: got %b want 1", i, in_ready); end
      if (in_ready) q_issue.push_back(e);
    end
    @(negedge CLK); idle_inputs(); #1;
    n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL starve_valid_low: got %b want 0", issue_valid); end
    @(negedge CLK); #1;
    n_cmp++; if (dut.r_count !== 3'd2) begin n_fail++; $display("FAIL starve_count: got %0d want 2", dut.r_count); end
    n_cmp++; if (n_issued - base !== 4) begin n_fail++; $display("FAIL starve_dispatched: got %0d want 4", n_issued - base); end
    @(negedge CLK); issue_credit = 1'b1;
    @(negedge CLK); idle_inputs(); #1;
    n_cmp++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL starve_fifth: got %b want 1", issue_valid); end
    @(negedge CLK); #1;
    n_cmp++; if (issue_valid !== 1'b0 || n_issued - base !== 5) begin n_fail++; $display("FAIL starve_after_credit: got valid %b issued %0d want 0 5", issue_valid, n_issued - base); end
  endtask

  task automatic test_full();
    entry_t e;
    entry_t a4;
    int base;
    do_reset();
    base = n_issued;
    for (int i = 0; i < 4; i++) begin   // cycles 0..3: drain all credits
      e = mk(32'h2000_0000 + 32'(i));
      @(negedge CLK); drive_push(e); #1;
      if (in_ready) q_issue.push_back(e);
    end
    @(negedge CLK); idle_inputs();       // cycles 4, 5
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin   // cycles 6..9
      e = mk(32'h3000_0000 + 32'(i));
      @(negedge CLK); drive_push(e); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_accept_%0d: got %b want 1", i, in_ready); end
      if (in_ready) q_issue.push_back(e);
    end
    a4 = mk(32'h3000_0004);
    @(negedge CLK); drive_push(a4); #1;  // cycle 10
    n_cmp++; if (in_ready !== 1'b0 || dut.r_count !== 3'd4) begin n_fail++; $display("FAIL full_ready_low: got ready %b count %0d want 0 4", in_ready, dut.r_count); end
    @(negedge CLK); #1;                  // cycle 11
    n_cmp++; if (issue_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_held: got valid %b ready %b want 0 0", issue_valid, in_ready); end
    @(negedge CLK); issue_credit = 1'b1; #1;  // cycle 12
    @(negedge CLK); #1;                  // cycle 13: pop but no bypass
    n_cmp++; if (in_ready !== 1'b0 || issue_valid !== 1'b1) begin n_fail++; $display("FAIL full_no_bypass: got ready %b valid %b want 0 1", in_ready, issue_valid); end
    @(negedge CLK); #1;                  // cycle 14: push and pop at DEPTH-1
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen: got %b want 1", in_ready); end
    if (in_ready) q_issue.push_back(a4);
    @(negedge CLK); in_valid = 1'b0; #1; // cycle 15
    n_cmp++; if (dut.r_count !== 3'd3) begin n_fail++; $display("FAIL full_simul_count: got %0d want 3", dut.r_count); end
    @(negedge CLK);                      // cycle 16
    @(negedge CLK); idle_inputs();       // cycle 17
    repeat (3) @(negedge CLK);
    #3;
    n_cmp++; if (n_issued - base !== 9 || q_issue.size() != 0) begin n_fail++; $display("FAIL full_drain: got issued %0d left %0d want 9 0", n_issued - base, q_issue.size()); end
  endtask

  task automatic test_simultaneous();
    entry_t e;
    do_reset();
    e = mk(32'h4000_0000);
    @(negedge CLK); drive_push(e); #1; if (in_ready) q_issue.push_back(e);   // c0
    @(negedge CLK); idle_inputs(); issue_credit = 1'b1; #1;                  // c1
    n_cmp++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL simul_disp0: got %b want 1", issue_valid); end
    e = mk(32'h4000_0001);
    @(negedge CLK); idle_inputs(); drive_push(e); #1; if (in_ready) q_issue.push_back(e);  // c2
    n_cmp++; if (dut.r_credits !== 4'd4 || credit_err !== 1'b0) begin n_fail++; $display("FAIL simul_credit_full: got %0d err %b want 4 0", dut.r_credits, credit_err); end
    @(negedge CLK); idle_inputs();                                           // c3
    vu_completed_valid = 1'b1; vu_completed_data = 64'h0000_0000_AAAA_0001;
    q_cmpl.push_back(64'h0000_0000_AAAA_0001); #1;
    n_cmp++; if (issue_valid !== 1'b1 || dut.r_outstanding !== 3'd1) begin n_fail++; $display("FAIL simul_pre: got valid %b outst %0d want 1 1", issue_valid, dut.r_outstanding); end
    e = mk(32'h4000_0002);
    @(negedge CLK); idle_inputs(); drive_push(e); #1; if (in_ready) q_issue.push_back(e);  // c4
    n_cmp++; if (dut.r_outstanding !== 3'd1 || dut.r_credits !== 4'd3) begin n_fail++; $display("FAIL simul_outst: got outst %0d credits %0d want 1 3", dut.r_outstanding, dut.r_credits); end
    n_cmp++; if (core_completed_valid !== 1'b1) begin n_fail++; $display("FAIL simul_cmpl: got %b want 1", core_completed_valid); end
    @(negedge CLK); idle_inputs(); issue_credit = 1'b1; #1;                  // c5
    n_cmp++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL simul_disp2: got %b want 1", issue_valid); end
    @(negedge CLK); idle_inputs(); #1;                                       // c6
    n_cmp++; if (dut.r_credits !== 4'd3 || dut.r_outstanding !== 3'd2 || credit_err !== 1'b0) begin n_fail++; $display("FAIL simul_mid: got credits %0d outst %0d err %b want 3 2 0", dut.r_credits, dut.r_outstanding, credit_err); end
  endtask

  task automatic test_errors();
    entry_t e;
    do_reset();
    @(negedge CLK); issue_credit = 1'b1;                                     // c0
    @(negedge CLK); idle_inputs();                                           // c1
    vu_completed_valid = 1'b1; vu_completed_data = 64'hDEAD_BEEF_DEAD_BEEF; #1;
    n_cmp++; if (dut.r_credits !== 4'd4 || credit_err !== 1'b1) begin n_fail++; $display("FAIL err_credit: got %0d err %b want 4 1", dut.r_credits, credit_err); end
    @(negedge CLK); idle_inputs(); #1;                                       // c2
    n_cmp++; if (core_completed_valid !== 1'b0 || cmpl_err !== 1'b1 || dut.r_outstanding !== 3'd0) begin n_fail++; $display("FAIL err_cmpl: got ccv %b err %b outst %0d want 0 1 0", core_completed_valid, cmpl_err, dut.r_outstanding); end
    e = mk(32'h5000_0000);
    @(negedge CLK); drive_push(e); #1; if (in_ready) q_issue.push_back(e);
    @(negedge CLK); idle_inputs();
    @(negedge CLK); vu_completed_valid = 1'b1; vu_completed_data = 64'h5555_0000_0000_0001;
    q_cmpl.push_back(64'h5555_0000_0000_0001);
    @(negedge CLK); idle_inputs(); #1;
    n_cmp++; if (core_completed_valid !== 1'b1 || {credit_err, cmpl_err} !== 2'b11) begin n_fail++; $display("FAIL err_sticky: got ccv %b errs %b want 1 11", core_completed_valid, {credit_err, cmpl_err}); end
    do_reset();
    #1;
    n_cmp++; if ({credit_err, cmpl_err} !== 2'b00) begin n_fail++; $display("FAIL err_clear: got %b want 00", {credit_err, cmpl_err}); end
  endtask

  task automatic test_flush_reset();
    entry_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin                                        // c0..c3
      e = mk(32'h6000_0000 + 32'(i));
      @(negedge CLK); drive_push(e); #1; if (in_ready) q_issue.push_back(e);
    end
    @(negedge CLK); idle_inputs();                                           // c4
    for (int i = 0; i < 3; i++) begin                                        // c5..c7
      e = mk(32'h6100_0000 + 32'(i));
      @(negedge CLK); drive_push(e); #1; if (in_ready) q_issue.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin                                        // c8..c10
      @(negedge CLK); idle_inputs();
      vu_completed_valid = 1'b1; vu_completed_data = 64'h6200_0000_0000_0000 + 64'(i);
      q_cmpl.push_back(64'h6200_0000_0000_0000 + 64'(i));
    end
    @(negedge CLK); idle_inputs();                                           // c11
    flush = 1'b1; issue_credit = 1'b1; drive_push(mk(32'h6300_0000)); #1;
    n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_issue: got %b want 0", issue_valid); end
    q_issue.delete();
    @(negedge CLK); idle_inputs(); #1;                                       // c12
    n_cmp++; if (dut.r_count !== 3'd0 || dut.r_outstanding !== 3'd1) begin n_fail++; $display("FAIL flush_state: got count %0d outst %0d want 0 1", dut.r_count, dut.r_outstanding); end
    n_cmp++; if (idle !== 1'b0 || dut.r_credits !== 4'd1) begin n_fail++; $display("FAIL flush_idle_credits: got idle %b credits %0d want 0 1", idle, dut.r_credits); end
    @(negedge CLK);                                                          // c13
    vu_completed_valid = 1'b1; vu_completed_data = 64'h6400_0000_0000_0000;
    q_cmpl.push_back(64'h6400_0000_0000_0000); #1;
    n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL flush_idle_wait: got %b want 0", idle); end
    @(negedge CLK); idle_inputs(); #1;                                       // c14
    n_cmp++; if (idle !== 1'b1 || core_completed_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done: got idle %b ccv %b want 1 1", idle, core_completed_valid); end
    e = mk(32'h6500_0000);
    @(negedge CLK); drive_push(e); #1; if (in_ready) q_issue.push_back(e);   // c15
    e = mk(32'h6500_0001);
    @(negedge CLK); drive_push(e); #1; if (in_ready) q_issue.push_back(e);   // c16
    #2;
    RST = 1'b1;                                                              // mid-cycle, clock low
    #1;
    n_cmp++; if ({in_ready, issue_valid, idle} !== 3'b101) begin n_fail++; $display("FAIL async_rst_outputs: got %b want 101", {in_ready, issue_valid, idle}); end
    n_cmp++; if (dut.r_credits !== 4'd4 || dut.r_count !== 3'd0) begin n_fail++; $display("FAIL async_rst_state: got credits %0d count %0d want 4 0", dut.r_credits, dut.r_count); end
    idle_inputs();
    q_issue.delete();
    q_cmpl.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    #3;
    n_cmp++; if (q_issue.size() != 0 || q_cmpl.size() != 0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL final_empty: got left %0d/%0d valid %b want 0/0 0", q_issue.size(), q_cmpl.size(), issue_valid); end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    n_issued = 0;
    RST      = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_starvation();
    test_full();
    test_simultaneous();
    test_errors();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
